// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller port between the cart PI reader and the ROM loader, one transaction at a time.
// Optional one-word cart prefetch buffer is enabled by defining SDRAM_ARB_CART_PREFETCH_EN.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned CART_STREAK_MAX = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cart_rd,
    input  logic [ADDR_W-1:0] cart_addr,
    output logic [15:0]       cart_data,
    output logic              cart_ack,
    input  logic              ldr_wr,
    input  logic              ldr_rd,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [15:0]       ldr_wdata,
    output logic [15:0]       ldr_rdata,
    output logic              ldr_ack,
    output logic              sd_wr,
    output logic              sd_rd,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [15:0]       sd_wdata,
    input  logic [15:0]       sd_rdata,
    input  logic              sd_wack,
    input  logic              sd_rack,
    output logic              err_timeout
);

    localparam int unsigned STREAK_W = $clog2(CART_STREAK_MAX + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0] TMO_DATA = 16'hDEAD;

`ifdef SDRAM_ARB_CART_PREFETCH_EN
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE, S_PREFETCH} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
`endif
    typedef enum logic [1:0] {G_CART, G_LDR_WR, G_LDR_RD} grant_t;

    state_t              state_q, state_d;
    grant_t              grant_q, grant_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                sd_rd_q, sd_rd_d;
    logic                sd_wr_q, sd_wr_d;
    logic [ADDR_W-1:0]   sd_addr_q, sd_addr_d;
    logic [15:0]         sd_wdata_q, sd_wdata_d;
    logic                cart_ack_q, cart_ack_d;
    logic [15:0]         cart_data_q, cart_data_d;
    logic                ldr_ack_q, ldr_ack_d;
    logic [15:0]         ldr_rdata_q, ldr_rdata_d;
    logic                err_q, err_d;
`ifdef SDRAM_ARB_CART_PREFETCH_EN
    logic [ADDR_W-1:0]   cart_last_q, cart_last_d;
    logic [ADDR_W-1:0]   pf_addr_q, pf_addr_d;
    logic [15:0]         pf_data_q, pf_data_d;
    logic                pf_valid_q, pf_valid_d;
    logic                pf_stale_q, pf_stale_d;
    logic                pf_stale_now;
`endif

    logic              ldr_req;
    logic              cart_blocked;
    logic [ADDR_W-1:0] cart_word;
    logic [ADDR_W-1:0] ldr_word;
    logic              ack_ok;
    logic              timed_out;
    logic [15:0]       rdata_sel;

    assign ldr_req      = ldr_wr | ldr_rd;
    assign cart_blocked = ldr_req && (streak_q == STREAK_W'(CART_STREAK_MAX));
    assign cart_word    = cart_addr & ~ADDR_W'(1);
    assign ldr_word     = ldr_addr & ~ADDR_W'(1);
    assign ack_ok       = (grant_q == G_LDR_WR) ? sd_wack : sd_rack;
    assign timed_out    = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign rdata_sel    = ack_ok ? sd_rdata : TMO_DATA;
`ifdef SDRAM_ARB_CART_PREFETCH_EN
    assign pf_stale_now = pf_stale_q | (ldr_wr && (ldr_word == sd_addr_q));
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        sd_rd_d     = sd_rd_q;
        sd_wr_d     = sd_wr_q;
        sd_addr_d   = sd_addr_q;
        sd_wdata_d  = sd_wdata_q;
        cart_ack_d  = 1'b0;
        cart_data_d = cart_data_q;
        ldr_ack_d   = 1'b0;
        ldr_rdata_d = ldr_rdata_q;
        err_d       = err_q;
`ifdef SDRAM_ARB_CART_PREFETCH_EN
        cart_last_d = cart_last_q;
        pf_addr_d   = pf_addr_q;
        pf_data_d   = pf_data_q;
        pf_valid_d  = pf_valid_q;
        pf_stale_d  = pf_stale_q;
`endif
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (!ldr_req) begin
                    streak_d = '0;
                end
                if (cart_rd && !cart_blocked) begin
                    grant_d = G_CART;
                    if (ldr_req && (streak_q != STREAK_W'(CART_STREAK_MAX))) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
`ifdef SDRAM_ARB_CART_PREFETCH_EN
                    if (pf_valid_q && (cart_word == pf_addr_q)) begin
                        cart_ack_d  = 1'b1;
                        cart_data_d = pf_data_q;
                        cart_last_d = pf_addr_q;
                        state_d     = S_DONE;
                    end else begin
                        pf_valid_d  = 1'b0;
                        cart_last_d = cart_word;
                        sd_rd_d     = 1'b1;
                        sd_addr_d   = cart_word;
                        state_d     = S_ISSUE;
                    end
`else
                    sd_rd_d   = 1'b1;
                    sd_addr_d = cart_word;
                    state_d   = S_ISSUE;
`endif
                end else if (ldr_req) begin
                    streak_d  = '0;
                    sd_addr_d = ldr_word;
                    state_d   = S_ISSUE;
                    if (ldr_wr) begin
                        grant_d    = G_LDR_WR;
                        sd_wr_d    = 1'b1;
                        sd_wdata_d = ldr_wdata;
`ifdef SDRAM_ARB_CART_PREFETCH_EN
                        if (ldr_word == pf_addr_q) begin
                            pf_valid_d = 1'b0;
                        end
`endif
                    end else begin
                        grant_d = G_LDR_RD;
                        sd_rd_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (ack_ok || timed_out) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = S_DONE;
                    if (!ack_ok) begin
                        err_d = 1'b1;
                    end
                    case (grant_q)
                        G_CART: begin
                            cart_ack_d  = 1'b1;
                            cart_data_d = rdata_sel;
                        end
                        G_LDR_RD: begin
                            ldr_ack_d   = 1'b1;
                            ldr_rdata_d = rdata_sel;
                        end
                        default: ldr_ack_d = 1'b1;
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef SDRAM_ARB_CART_PREFETCH_EN
                // Follow every cart completion with a read of the next word while the loader is quiet
                if ((grant_q == G_CART) && !ldr_req) begin
                    sd_rd_d    = 1'b1;
                    sd_addr_d  = cart_last_q + ADDR_W'(2);
                    pf_stale_d = 1'b0;
                    tmo_d      = '0;
                    state_d    = S_PREFETCH;
                end
`endif
            end
`ifdef SDRAM_ARB_CART_PREFETCH_EN
            S_PREFETCH: begin
                tmo_d      = tmo_q + TMO_W'(1);
                pf_stale_d = pf_stale_now;
                if (sd_rack || timed_out) begin
                    sd_rd_d = 1'b0;
                    state_d = S_IDLE;
                    if (!sd_rack) begin
                        err_d = 1'b1;
                    end else if (!pf_stale_now) begin
                        if (cart_rd && (cart_word == sd_addr_q)) begin
                            cart_ack_d  = 1'b1;
                            cart_data_d = sd_rdata;
                            cart_last_d = sd_addr_q;
                            grant_d     = G_CART;
                            state_d     = S_DONE;
                        end else begin
                            pf_valid_d = 1'b1;
                            pf_addr_d  = sd_addr_q;
                            pf_data_d  = sd_rdata;
                        end
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            grant_q     <= G_CART;
            streak_q    <= '0;
            tmo_q       <= '0;
            sd_rd_q     <= 1'b0;
            sd_wr_q     <= 1'b0;
            sd_addr_q   <= '0;
            sd_wdata_q  <= '0;
            cart_ack_q  <= 1'b0;
            cart_data_q <= '0;
            ldr_ack_q   <= 1'b0;
            ldr_rdata_q <= '0;
            err_q       <= 1'b0;
`ifdef SDRAM_ARB_CART_PREFETCH_EN
            cart_last_q <= '0;
            pf_addr_q   <= '0;
            pf_data_q   <= '0;
            pf_valid_q  <= 1'b0;
            pf_stale_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            sd_rd_q     <= sd_rd_d;
            sd_wr_q     <= sd_wr_d;
            sd_addr_q   <= sd_addr_d;
            sd_wdata_q  <= sd_wdata_d;
            cart_ack_q  <= cart_ack_d;
            cart_data_q <= cart_data_d;
            ldr_ack_q   <= ldr_ack_d;
            ldr_rdata_q <= ldr_rdata_d;
            err_q       <= err_d;
`ifdef SDRAM_ARB_CART_PREFETCH_EN
            cart_last_q <= cart_last_d;
            pf_addr_q   <= pf_addr_d;
            pf_data_q   <= pf_data_d;
            pf_valid_q  <= pf_valid_d;
            pf_stale_q  <= pf_stale_d;
`endif
        end
    end

    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_addr     = sd_addr_q;
    assign sd_wdata    = sd_wdata_q;
    assign cart_ack    = cart_ack_q;
    assign cart_data   = cart_data_q;
    assign ldr_ack     = ldr_ack_q;
    assign ldr_rdata   = ldr_rdata_q;
    assign err_timeout = err_q;

endmodule
